// File: rtl/ahb_dec_mux.sv
// AHB-Lite address decoder and response multiplexer with built-in default slave.
// Unmapped NONSEQ/SEQ transfers receive a two-cycle ERROR response.
module ahb_dec_mux #(
    parameter int                    NUM_S  = 3,
    parameter int                    DATA_W = 32,
    parameter logic [NUM_S*16-1:0]   S_BASE = {16'h0020, 16'h0010, 16'h0000},
    parameter logic [NUM_S*16-1:0]   S_MASK = {3{16'hFFF0}},
    parameter int                    CNT_W  = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [31:0]               HADDR,
    input  logic [1:0]                HTRANS,
    output logic [NUM_S-1:0]          HSEL,
    output logic                      HSELd,
    input  logic [NUM_S-1:0]          HREADYOUT_S,
    input  logic [NUM_S-1:0]          HRESP_S,
    input  logic [NUM_S*DATA_W-1:0]   HRDATA_S,
    output logic                      HREADY,
    output logic                      HRESP,
    output logic [DATA_W-1:0]         HRDATA,
    output logic [CNT_W-1:0]          ERR_CNT,
    input  logic                      ERR_CLR
);

    // state   | meaning
    // DS_IDLE | default slave idle, zero-wait OKAY
    // DS_ERR1 | first ERROR cycle, HREADY low
    // DS_ERR2 | second ERROR cycle, HREADY high
    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    ds_state_t        state, state_nxt;
    logic [NUM_S:0]   dsel;
    logic             hit_found;
    logic             err_start;
    logic             err_inc;
    logic             ds_ready;
    logic             ds_resp;
    logic             addr_unused;

    assign addr_unused = ^{HADDR[15:0], HTRANS[0]};

    // Lowest index wins on overlapping regions.
    always_comb begin
        HSEL      = '0;
        hit_found = 1'b0;
        for (int i = 0; i < NUM_S; i++) begin
            if (!hit_found &&
                ((HADDR[31:16] & S_MASK[i*16 +: 16]) == S_BASE[i*16 +: 16])) begin
                HSEL[i]   = 1'b1;
                hit_found = 1'b1;
            end
        end
        HSELd = ~hit_found;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel <= (NUM_S+1)'(1) << NUM_S;
        end else if (HREADY) begin
            dsel <= {HSELd, HSEL};
        end
    end

    assign err_start = HREADY & HSELd & HTRANS[1];
    assign err_inc   = err_start & (state != DS_ERR1);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= DS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ds_ready  = 1'b1;
        ds_resp   = 1'b0;
        case (state)
            DS_IDLE: begin
                if (err_start) state_nxt = DS_ERR1;
            end
            DS_ERR1: begin
                ds_ready  = 1'b0;
                ds_resp   = 1'b1;
                state_nxt = DS_ERR2;
            end
            DS_ERR2: begin
                ds_resp   = 1'b1;
                state_nxt = err_start ? DS_ERR1 : DS_IDLE;
            end
            default: state_nxt = DS_IDLE;
        endcase
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        if (dsel[NUM_S]) begin
            HREADY = ds_ready;
            HRESP  = ds_resp;
        end
        for (int i = 0; i < NUM_S; i++) begin
            if (dsel[i]) begin
                HREADY = HREADYOUT_S[i];
                HRESP  = HRESP_S[i];
                HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
            end
        end
    end

    // Clear has priority over a coincident increment.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ERR_CNT <= '0;
        end else if (ERR_CLR) begin
            ERR_CNT <= '0;
        end else if (err_inc && (ERR_CNT != {CNT_W{1'b1}})) begin
            ERR_CNT <= ERR_CNT + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ahb_dec_mux.sv
// Scoreboard bench for ahb_dec_mux: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ahb_dec_mux;

    localparam int NUM_S  = 3;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;
    // Slave 1 region (base 0x0000, mask 0xFFE0) overlaps slave 0 at 0x0000.
    localparam logic [47:0] BASE = {16'h0020, 16'h0000, 16'h0000};
    localparam logic [47:0] MASK = {16'hFFF0, 16'hFFE0, 16'hFFF0};

    logic                     HCLK = 1'b0;
    logic                     HRESETn = 1'b0;
    logic [31:0]              HADDR = 32'h0010_0000;
    logic [1:0]               HTRANS = 2'b00;
    logic [NUM_S-1:0]         HSEL;
    logic                     HSELd;
    logic [NUM_S-1:0]         HREADYOUT_S = 3'b111;
    logic [NUM_S-1:0]         HRESP_S = 3'b000;
    logic [NUM_S*DATA_W-1:0]  HRDATA_S = {32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    logic                     HREADY;
    logic                     HRESP;
    logic [DATA_W-1:0]        HRDATA;
    logic [CNT_W-1:0]         ERR_CNT;
    logic                     ERR_CLR = 1'b0;

    ahb_dec_mux #(
        .NUM_S  (NUM_S),
        .DATA_W (DATA_W),
        .S_BASE (BASE),
        .S_MASK (MASK),
        .CNT_W  (CNT_W)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HSEL        (HSEL),
        .HSELd       (HSELd),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA_S    (HRDATA_S),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA),
        .ERR_CNT     (ERR_CNT),
        .ERR_CLR     (ERR_CLR)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string       name;
        logic [2:0]  hsel;
        logic        hseld;
        logic        hready;
        logic        hresp;
        logic [31:0] hrdata;
        logic [1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;

    always @(negedge HCLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if ({HSEL, HSELd, HREADY, HRESP, HRDATA, ERR_CNT} !==
                {e.hsel, e.hseld, e.hready, e.hresp, e.hrdata, e.cnt}) begin
                n_fail++;
                $display("FAIL %s: got hsel=%b hseld=%b rdy=%b resp=%b data=%h cnt=%0d, expected hsel=%b hseld=%b rdy=%b resp=%b data=%h cnt=%0d",
                         e.name, HSEL, HSELd, HREADY, HRESP, HRDATA, ERR_CNT,
                         e.hsel, e.hseld, e.hready, e.hresp, e.hrdata, e.cnt);
            end
        end
    end

    task automatic step(input string nm, input logic rst, input logic [31:0] a,
                        input logic [1:0] t, input logic [2:0] rdy, input logic [2:0] rsp,
                        input logic clr, input logic [2:0] e_hsel, input logic e_hseld,
                        input logic e_rdy, input logic e_resp, input logic [31:0] e_data,
                        input logic [1:0] e_cnt);
        exp_t e;
        @(posedge HCLK);
        #1;
        HRESETn     = rst;
        HADDR       = a;
        HTRANS      = t;
        HREADYOUT_S = rdy;
        HRESP_S     = rsp;
        ERR_CLR     = clr;
        e.name = nm; e.hsel = e_hsel; e.hseld = e_hseld; e.hready = e_rdy;
        e.hresp = e_resp; e.hrdata = e_data; e.cnt = e_cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        // reset and decode during reset
        step("rst_decode",  0, 32'h0010_0000, IDLE, 3'b111, 3'b000, 0, 3'b010, 0, 1, 0, 32'h0, 0);
        step("rst_release", 1, 32'h0010_0000, IDLE, 3'b111, 3'b000, 0, 3'b010, 0, 1, 0, 32'h0, 0);
        // mapped read with one wait state from slave 2
        step("rd_addr",     1, 32'h0020_0004, NSEQ, 3'b111, 3'b000, 0, 3'b100, 0, 1, 0, 32'hCAFE_0001, 0);
        step("rd_wait",     1, 32'h0000_0000, IDLE, 3'b011, 3'b000, 0, 3'b001, 0, 0, 0, 32'hCAFE_0002, 0);
        step("rd_done",     1, 32'h0000_0000, IDLE, 3'b111, 3'b000, 0, 3'b001, 0, 1, 0, 32'hCAFE_0002, 0);
        // unmapped NONSEQ, master changes address during ERR1
        step("um_addr",     1, 32'h0040_0000, NSEQ, 3'b111, 3'b000, 0, 3'b000, 1, 1, 0, 32'hCAFE_0000, 0);
        step("um_err1",     1, 32'h0000_0000, IDLE, 3'b111, 3'b000, 0, 3'b001, 0, 0, 1, 32'h0, 1);
        step("um_err2",     1, 32'h0040_0000, IDLE, 3'b111, 3'b000, 0, 3'b000, 1, 1, 1, 32'h0, 1);
        step("um_idle_ok",  1, 32'h0040_0000, IDLE, 3'b111, 3'b000, 0, 3'b000, 1, 1, 0, 32'h0, 1);
        // back-to-back errors, counter saturation at 3
        step("b2b_addr",    1, 32'h0040_0000, NSEQ, 3'b111, 3'b000, 0, 3'b000, 1, 1, 0, 32'h0, 1);
        step("b2b_err1a",   1, 32'h0040_0004, SEQ,  3'b111, 3'b000, 0, 3'b000, 1, 0, 1, 32'h0, 2);
        step("b2b_err2a",   1, 32'h0040_0004, SEQ,  3'b111, 3'b000, 0, 3'b000, 1, 1, 1, 32'h0, 2);
        step("b2b_err1b",   1, 32'h0040_0008, SEQ,  3'b111, 3'b000, 0, 3'b000, 1, 0, 1, 32'h0, 3);
        step("b2b_err2b",   1, 32'h0040_0000, NSEQ, 3'b111, 3'b000, 0, 3'b000, 1, 1, 1, 32'h0, 3);
        step("sat_err1",    1, 32'h0040_0000, NSEQ, 3'b111, 3'b000, 0, 3'b000, 1, 0, 1, 32'h0, 3);
        step("clr_err2",    1, 32'h0040_0000, NSEQ, 3'b111, 3'b000, 1, 3'b000, 1, 1, 1, 32'h0, 3);
        step("clr_err1",    1, 32'h0040_0000, NSEQ, 3'b111, 3'b000, 0, 3'b000, 1, 0, 1, 32'h0, 0);
        step("cnt_err2",    1, 32'h0040_0000, NSEQ, 3'b111, 3'b000, 0, 3'b000, 1, 1, 1, 32'h0, 0);
        // reset asserted during ERR1 takes effect immediately
        step("rst_in_err1", 0, 32'h0040_0000, IDLE, 3'b111, 3'b000, 0, 3'b000, 1, 1, 0, 32'h0, 0);
        step("post_rst",    1, 32'h0000_0000, IDLE, 3'b111, 3'b000, 0, 3'b001, 0, 1, 0, 32'h0, 0);
        // overlap decode and slave ERROR passthrough
        step("ovl_addr",    1, 32'h0000_0000, NSEQ, 3'b111, 3'b000, 0, 3'b001, 0, 1, 0, 32'hCAFE_0000, 0);
        step("s_err_wait",  1, 32'h0010_0000, IDLE, 3'b110, 3'b001, 0, 3'b010, 0, 0, 1, 32'hCAFE_0000, 0);
        step("s_err_done",  1, 32'h0010_0000, IDLE, 3'b111, 3'b001, 0, 3'b010, 0, 1, 1, 32'hCAFE_0000, 0);
        step("s1_data",     1, 32'h0010_0000, IDLE, 3'b111, 3'b000, 0, 3'b010, 0, 1, 0, 32'hCAFE_0001, 0);

        repeat (3) @(posedge HCLK);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_dec_mux.md
# ahb_dec_mux

Parametrised AHB-Lite address decoder and slave-to-master response multiplexer with a built-in default slave. It decodes `HADDR[31:16]` against per-slave base/mask pairs to drive `HSEL`. It registers the data-phase selection and muxes `HRDATA`/`HREADY`/`HRESP` back to the master. Unmapped NONSEQ/SEQ transfers get a protocol-correct two-cycle ERROR response. The block sits between the single AHB-Lite master and `NUM_S` slaves and replaces the fixed three-slave decoder.

## Interface
- `NUM_S`, 3: number of slaves, legal range 1..8.
- `DATA_W`, 32: read data width.
- `S_BASE`, {16'h0020,16'h0010,16'h0000}: packed `NUM_S*16` bits; slice i is the base of slave i compared with `HADDR[31:16]`.
- `S_MASK`, {3{16'hFFF0}}: packed `NUM_S*16` bits; slice i is the compare mask of slave i.
- `CNT_W`, 8: error counter width.
- `HCLK`  in  1  clock, single domain.
- `HRESETn`  in  1  asynchronous active-low reset.
- `HADDR`  in  32  master address.
- `HTRANS`  in  2  master transfer type.
- `HSEL`  out  NUM_S  one-hot slave select, address phase.
- `HSELd`  out  1  default-slave select, address phase.
- `HREADYOUT_S`  in  NUM_S  per-slave ready.
- `HRESP_S`  in  NUM_S  per-slave response (1 = ERROR).
- `HRDATA_S`  in  NUM_S*DATA_W  per-slave read data, slice i = slave i.
- `HREADY`  out  1  muxed ready to master and all slaves.
- `HRESP`  out  1  muxed response to master.
- `HRDATA`  out  DATA_W  muxed read data.
- `ERR_CNT`  out  CNT_W  saturating count of default-slave ERROR responses.
- `ERR_CLR`  in  1  synchronous clear of `ERR_CNT`.

## Operation
- **Address decode (combinational):** slave i hits when `(HADDR[31:16] & S_MASK[i]) == S_BASE[i]`.
  - On overlap, the lowest index wins.
  - If nothing hits, `HSELd`=1.
  - Exactly one of `{HSELd, HSEL}` is high at all times, independent of `HTRANS`.
- **Data-phase select `dsel` (NUM_S+1 bits, one-hot):** loads the decode result on every `HCLK` edge with `HREADY`=1. It holds while `HREADY`=0.
- **Response mux:** when `dsel` selects slave i, `HREADY`=`HREADYOUT_S[i]`, `HRESP`=`HRESP_S[i]` and `HRDATA`=slice i.
- **Default-slave FSM,** states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE → DS_ERR1 on a sampled address phase (`HREADY`=1) with `HSELd`=1 and `HTRANS[1]`=1 (NONSEQ/SEQ).
  - DS_ERR1 → DS_ERR2 unconditionally.
  - DS_ERR2 → DS_ERR1 if the new sampled phase is again unmapped NONSEQ/SEQ; otherwise DS_ERR2 → DS_IDLE.
- **Default-slave outputs** (apply when `dsel` selects the default slave):
  - DS_IDLE: `HREADY`=1, `HRESP`=0.
  - DS_ERR1: `HREADY`=0, `HRESP`=1.
  - DS_ERR2: `HREADY`=1, `HRESP`=1.
  - `HRDATA`=0 in all three states.
- **Unmapped IDLE/BUSY:** an IDLE or BUSY transfer to an unmapped address gets a zero-wait OKAY.
- **`ERR_CNT`:**
  - Increments by 1 on each DS_IDLE→DS_ERR1 or DS_ERR2→DS_ERR1 transition.
  - Saturates at all-ones.
  - `ERR_CLR`=1 forces 0 next cycle. Clear wins over a simultaneous increment.

## Timing
- **Reset values (`HRESETn`=0):**
  - `dsel` = default slave; FSM = DS_IDLE.
  - So `HREADY`=1, `HRESP`=0, `HRDATA`=0.
  - `ERR_CNT`=0.
  - `HSEL`/`HSELd` follow `HADDR` combinationally, also during reset.
- **Decode latency:** `HSEL` has zero-cycle latency from `HADDR`. The response mux switches one cycle after the sampling edge, i.e. in the data phase.
- **Wait states:** a slave wait state (`HREADYOUT_S[i]`=0) stalls `dsel`. The next address is not sampled until `HREADY`=1.
- **ERROR timing:** an unmapped transfer ERROR takes exactly 2 data-phase cycles.
  - Address changes or `HTRANS`→IDLE driven by the master during DS_ERR1 are ignored, because `HREADY`=0.
  - Back-to-back unmapped transfers produce ERR1, ERR2, ERR1, ERR2 with no IDLE gap.
- **Reset mid-transfer:** asserting `HRESETn` during DS_ERR1/ERR2 or a slave wait returns all state to the reset values immediately (asynchronously). No pending response completes.

## Test plan
1. **Reset check:** hold reset, then release with `HTRANS`=IDLE → `HREADY`=1, `HRESP`=0, `HRDATA`=0, `ERR_CNT`=0. `HADDR`=32'h0010_0000 → `HSEL`=3'b010 during reset.
2. **Mapped read:**
   - NONSEQ to 32'h0020_0004, `HRDATA_S` slice 2 = 32'hCAFE_0002, slave 2 inserts 1 wait state.
   - Required: `HSEL`=3'b100 in the address cycle.
   - Required: `HREADY`=0 then 1 in the data phase, `HRDATA`=32'hCAFE_0002 on the completing cycle.
3. **Unmapped NONSEQ:** to 32'h0040_0000 → `HSELd`=1; the data phase shows `HREADY`/`HRESP` = 0/1 then 1/1; `ERR_CNT`=1. An unmapped IDLE to the same address → 1/0 in one cycle, `ERR_CNT` unchanged.
4. **Back-to-back errors:** unmapped NONSEQ, then SEQ (presented in ERR2) → two consecutive 2-cycle ERROR responses with no OKAY cycle between them; `ERR_CNT`=2.
5. **Counter saturation and clear:**
   - With `CNT_W`=2, run 5 unmapped transfers → `ERR_CNT` saturates at 3.
   - `ERR_CLR` pulsed on the cycle of a new ERR1 entry → `ERR_CNT`=0.
6. **Overlap and reset mid-error:**
   - Use `S_MASK[1]`=16'hFFE0 so the slave 1 region overlaps slave 0 for `HADDR[31:16]`=16'h0000 → `HSEL`=3'b001 (lowest index wins).
   - Assert `HRESETn` during DS_ERR1 → `HREADY`=1 and `HRESP`=0 immediately; the FSM is in DS_IDLE after release.
